pfpu_dma_sink: RTL

- Wishbone slave that terminates the PFPU vertex DMA master (wbm_adr_o/wbm_dat_o/wbm_cyc_o/wbm_stb_o/wbm_ack_i).
- Accepts single-word writes and acknowledges them with a programmable number of wait states.
- Stores in-window words into a local buffer RAM and counts accepted and stray writes.
- Used as the mesh-buffer endpoint in integration and as a deterministic responder for PFPU verification.

---
 rtl/pfpu_dma_sink_pkg.sv | 29 ++
 rtl/pfpu_dma_sink_ram.sv | 36 +++
 rtl/pfpu_dma_sink.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pfpu_dma_sink_pkg.sv
// Shared types and helpers for the PFPU vertex-DMA sink: FSM encoding,
// default sizes and the saturating counter increment.
package pfpu_dma_pkg;

    localparam int DEPTH_LOG2_DEF = 8;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } dma_state_e;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        if (w >= 32) begin
            max_v = 32'hFFFF_FFFF;
        end else begin
            max_v = (32'd1 << w) - 32'd1;
        end
        if (v >= max_v) begin
            return max_v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/pfpu_dma_sink_ram.sv
// Mesh buffer storage: one synchronous write port and one synchronous
// read-before-write read port, shaped to map onto block RAM.
module pfpu_dma_sink_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_adr,
    input  logic [31:0]       wr_dat,
    input  logic [ADDR_W-1:0] rd_adr,
    output logic [31:0]       rd_dat
);

    logic [31:0] mem_r [0:(1<<ADDR_W)-1];
    logic [31:0] rd_dat_r;

    // Write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_adr] <= wr_dat;
        end
    end

    // Read port; a same-edge write to the same word returns the old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_r <= 32'd0;
        end else begin
            rd_dat_r <= mem_r[rd_adr];
        end
    end

    assign rd_dat = rd_dat_r;

endmodule

// File: rtl/pfpu_dma_sink.sv
// Wishbone slave terminating the PFPU vertex DMA: acks single writes after
// a programmable delay, stores in-window words and counts good/stray accesses.
module pfpu_dma_sink
    import pfpu_dma_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    output logic                  wbs_ack_o,
    input  logic [31:0]           base_i,
    input  logic [3:0]            wait_i,
    input  logic [CNT_W-1:0]      expect_i,
    input  logic                  clear_i,
    input  logic [DEPTH_LOG2-1:0] rd_adr_i,
    output logic [31:0]           rd_dat_o,
    output logic [CNT_W-1:0]      write_count_o,
    output logic [CNT_W-1:0]      stray_count_o,
    output logic                  done_o
);

    localparam logic [31:0] WIN_BYTES = 32'd4 << DEPTH_LOG2;

    dma_state_e            state_r, state_s;
    logic [3:0]            cnt_r, cnt_s;
    logic                  latch_s;
    logic                  win_r;
    logic [DEPTH_LOG2-1:0] idx_r;
    logic [31:0]           dat_r;
    logic                  ack_r;
    logic [CNT_W-1:0]      wc_r, wc_s, sc_r, sc_s;
    logic                  done_r, done_s;
    logic [31:0]           off_s;
    logic                  in_win_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic                  wr_en_s;

    // Address decode against the buffer window.
    always_comb begin
        off_s    = wbs_adr_i - base_i;
        in_win_s = wbs_we_i & (wbs_adr_i[1:0] == 2'b00) & (off_s < WIN_BYTES);
        idx_s    = off_s[DEPTH_LOG2+1:2];
    end

    // Transfer FSM next-state; the bus is only looked at in IDLE and WAIT.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        latch_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    latch_s = 1'b1;
                    cnt_s   = wait_i;
                    if (wait_i == 4'd0) begin
                        state_s = ST_ACK;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_s = cnt_r - 4'd1;
                if (!wbs_cyc_i) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == 4'd1) begin
                    state_s = ST_ACK;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Counter and done update; clear wins over a same-cycle increment.
    always_comb begin
        wc_s = wc_r;
        sc_s = sc_r;
        if (clear_i) begin
            wc_s = {CNT_W{1'b0}};
            sc_s = {CNT_W{1'b0}};
        end else if (state_r == ST_ACK) begin
            if (win_r) begin
                wc_s = CNT_W'(sat_inc(32'(wc_r), CNT_W));
            end else begin
                sc_s = CNT_W'(sat_inc(32'(sc_r), CNT_W));
            end
        end else begin
            wc_s = wc_r;
        end
        if (clear_i) begin
            done_s = 1'b0;
        end else begin
            done_s = done_r | ((expect_i != {CNT_W{1'b0}}) && (wc_s >= expect_i));
        end
    end

    // FSM, latched request and counters.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            win_r   <= 1'b0;
            idx_r   <= {DEPTH_LOG2{1'b0}};
            dat_r   <= 32'd0;
            ack_r   <= 1'b0;
            wc_r    <= {CNT_W{1'b0}};
            sc_r    <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ack_r   <= (state_s == ST_ACK);
            wc_r    <= wc_s;
            sc_r    <= sc_s;
            done_r  <= done_s;
            if (latch_s) begin
                win_r <= in_win_s;
                idx_r <= idx_s;
                dat_r <= wbs_dat_i;
            end
        end
    end

    assign wr_en_s = (state_r == ST_ACK) & win_r;

    pfpu_dma_sink_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .wr_en  (wr_en_s),
        .wr_adr (idx_r),
        .wr_dat (dat_r),
        .rd_adr (rd_adr_i),
        .rd_dat (rd_dat_o)
    );

    assign wbs_ack_o     = ack_r;
    assign write_count_o = wc_r;
    assign stray_count_o = sc_r;
    assign done_o        = done_r;

endmodule
